fusion_accumulator: RTL and testbench

- Downstream stage of the fused bitbrick multiplier (quarter_unit); consumes its packed 16-bit product word each beat.
- Unpacks 1, 2 or 4 signed product lanes according to precision mode and accumulates each lane into its own ACC_W-bit register across a dot-product burst.
- Presents the per-lane sums to the output-buffer stage over a valid/ready handshake.

---
 rtl/fusion_pkg.sv | 23 ++
 rtl/fusion_lane_acc.sv | 63 ++++++
 rtl/fusion_accumulator.sv | 140 ++++++++++++++
 tb/tb_fusion_accumulator.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
// Shared types and constants for the fusion accumulator slice.
// Optional saturation build: define FUSION_ACC_SAT_EN (default build wraps).
package fusion_pkg;

  localparam int NUM_LANES  = 4;
  localparam int LANE_W_4X4 = 4;
  localparam int LANE_W_2X6 = 6;
  localparam int LANE_W_1X8 = 8;

  typedef enum logic [1:0] {
    MODE_4X4 = 2'b00,
    MODE_2X6 = 2'b01,
    MODE_1X8 = 2'b10,
    MODE_ILL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/fusion_lane_acc.sv
// One lane accumulator: sign-extends the raw lane bits, loads or adds, flags overflow.
// FUSION_ACC_SAT_EN selects clamping on overflow; otherwise the sum wraps.
module fusion_lane_acc
  import fusion_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  add,
  input  logic [1:0]            mode,
  input  logic [LANE_W_1X8-1:0] raw,
  output logic [ACC_W-1:0]      acc,
  output logic                  ovf
);

  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] add_result;
  logic             ovf_now;

  always_comb begin
    ext = '0;
    case (mode_e'(mode))
      MODE_4X4: ext = {{(ACC_W-LANE_W_4X4){raw[LANE_W_4X4-1]}}, raw[LANE_W_4X4-1:0]};
      MODE_2X6: ext = {{(ACC_W-LANE_W_2X6){raw[LANE_W_2X6-1]}}, raw[LANE_W_2X6-1:0]};
      MODE_1X8: ext = {{(ACC_W-LANE_W_1X8){raw[LANE_W_1X8-1]}}, raw[LANE_W_1X8-1:0]};
      default:  ext = '0;
    endcase
  end

  assign sum     = acc_reg + ext;
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign ovf_now = (acc_reg[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_reg[ACC_W-1]);

`ifdef FUSION_ACC_SAT_EN
  assign add_result = !ovf_now          ? sum :
                      acc_reg[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                          {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign add_result = sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (load) begin
      acc_reg <= ext;
      ovf_reg <= 1'b0;
    end else if (add) begin
      acc_reg <= add_result;
      ovf_reg <= ovf_reg | ovf_now;
    end
  end

  assign acc = acc_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/fusion_accumulator.sv
// Per-lane dot-product accumulator behind the fused bitbrick multiplier.
// FUSION_ACC_SAT_EN: lanes saturate on overflow instead of wrapping.
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]           out_beats,
  output logic [NUM_LANES-1:0]       out_ovf,
  output logic                       out_err
);

  state_e           state_reg;
  mode_e            mode_reg;
  logic [CNT_W-1:0] beats_reg;
  logic             err_reg;
  logic             valid_reg;

  logic             accept;
  logic             start;
  logic             add;
  mode_e            eff_mode;
  logic [CNT_W-1:0] beats_inc;
  logic             at_max;

  assign in_ready  = !valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  // A beat accepted outside ACCUM always opens a burst, including the no-bubble HOLD case.
  assign start     = accept && (state_reg != ACCUM);
  assign add       = accept && (state_reg == ACCUM);
  assign eff_mode  = start ? mode_e'(mode) : mode_reg;
  assign beats_inc = beats_reg + 1'b1;
  assign at_max    = (beats_inc == CNT_W'(MAX_BEATS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mode_reg  <= MODE_4X4;
      beats_reg <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (start) begin
            mode_reg  <= mode_e'(mode);
            beats_reg <= CNT_W'(1);
            err_reg   <= (mode_e'(mode) == MODE_ILL);
            valid_reg <= in_last;
            state_reg <= in_last ? HOLD : ACCUM;
          end else if ((state_reg == HOLD) && out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        ACCUM: begin
          if (add) begin
            beats_reg <= beats_inc;
            if (in_last) begin
              valid_reg <= 1'b1;
              state_reg <= HOLD;
            end else if (at_max) begin
              valid_reg <= 1'b1;
              err_reg   <= 1'b1;
              state_reg <= HOLD;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LANE_W_2X6-1:0] six_bits;
      logic [LANE_W_1X8-1:0] byte_bits;
      logic [LANE_W_1X8-1:0] raw;
      logic [ACC_W-1:0]      lane_acc;
      logic                  lane_ovf;

      if (gi < 2) begin : g_six
        assign six_bits = in_data[8*gi +: LANE_W_2X6];
      end else begin : g_six_off
        assign six_bits = '0;
      end

      if (gi == 0) begin : g_byte
        assign byte_bits = in_data[LANE_W_1X8-1:0];
      end else begin : g_byte_off
        assign byte_bits = '0;
      end

      // Raw lane bits are zero-padded here; sign extension happens in the lane.
      always_comb begin
        raw = '0;
        case (eff_mode)
          MODE_4X4: raw[LANE_W_4X4-1:0] = in_data[4*gi +: LANE_W_4X4];
          MODE_2X6: raw[LANE_W_2X6-1:0] = six_bits;
          MODE_1X8: raw                 = byte_bits;
          default:  raw                 = '0;
        endcase
      end

      fusion_lane_acc #(
        .ACC_W (ACC_W)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start),
        .add   (add),
        .mode  (eff_mode),
        .raw   (raw),
        .acc   (lane_acc),
        .ovf   (lane_ovf)
      );

      assign out_acc[gi*ACC_W +: ACC_W] = lane_acc;
      assign out_ovf[gi]                = lane_ovf;
    end
  endgenerate

  assign out_valid = valid_reg;
  assign out_beats = beats_reg;
  assign out_err   = err_reg;

endmodule

// File: tb/tb_fusion_accumulator.sv
// Scoreboard bench for fusion_accumulator; two instances (long bursts and MAX_BEATS = 4).
module tb_fusion_accumulator;

  localparam int ACC_W   = 10;
  localparam int CNT_W   = 9;
  localparam int M_CNT_W = 3;

  typedef struct {
    logic [4*ACC_W-1:0] acc;
    logic [CNT_W-1:0]   beats;
    logic [3:0]         ovf;
    logic               err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [1:0]         mode;
  logic               in_valid, in_ready, in_last;
  logic [15:0]        in_data;
  logic               out_valid, out_ready;
  logic [4*ACC_W-1:0] out_acc;
  logic [CNT_W-1:0]   out_beats;
  logic [3:0]         out_ovf;
  logic               out_err;

  logic [1:0]         m_mode;
  logic               m_in_valid, m_in_ready, m_in_last;
  logic [15:0]        m_in_data;
  logic               m_out_valid, m_out_ready;
  logic [4*ACC_W-1:0] m_out_acc;
  logic [M_CNT_W-1:0] m_out_beats;
  logic [3:0]         m_out_ovf;
  logic               m_out_err;

  fusion_accumulator #(.ACC_W(ACC_W), .MAX_BEATS(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_beats(out_beats), .out_ovf(out_ovf), .out_err(out_err)
  );

  fusion_accumulator #(.ACC_W(ACC_W), .MAX_BEATS(4)) u_max (
    .clk(clk), .rst_n(rst_n), .mode(m_mode), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_data(m_in_data), .in_last(m_in_last), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_acc(m_out_acc), .out_beats(m_out_beats), .out_ovf(m_out_ovf), .out_err(m_out_err)
  );

  function automatic logic [4*ACC_W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic exp_t mk_exp(input logic [4*ACC_W-1:0] acc, input int beats,
                                  input logic [3:0] ovf, input logic err);
    exp_t e;
    e.acc = acc; e.beats = CNT_W'(beats); e.ovf = ovf; e.err = err;
    return e;
  endfunction

  // Entered and left at #1 after a rising edge; the DUT is expected to be ready.
  task automatic send_beat(input bit to_max, input logic [15:0] d, input logic last);
    if (to_max) begin
      m_in_valid = 1'b1; m_in_data = d; m_in_last = last;
    end else begin
      in_valid = 1'b1; in_data = d; in_last = last;
    end
    @(posedge clk); #1;
    m_in_valid = 1'b0; m_in_last = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    m_mode = 2'b00; m_in_valid = 1'b0; m_in_last = 1'b0; m_in_data = '0; m_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_acc !== '0) begin miscompares++; $display("FAIL reset_acc: got %h want 0", out_acc); end
    vectors++; if (out_beats !== '0) begin miscompares++; $display("FAIL reset_beats: got %0d want 0", out_beats); end
    vectors++; if (out_ovf !== 4'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0000", out_ovf); end
    vectors++; if (out_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", out_err); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    $display("reset: outputs checked after release");
  endtask

  task automatic test_4x4();
    exp_t e;
    mode = 2'b00;
    send_beat(1'b0, 16'h12F3, 1'b0);
    mode = 2'b10;
    in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b1;
    sb.push_back(mk_exp(pack4(4, 0, 3, 2), 2, 4'b0000, 1'b0));
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL 4x4_early_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL 4x4_latency: got %b want 1", out_valid); end
    e = sb.pop_front();
    vectors++; if (out_acc !== e.acc) begin miscompares++; $display("FAIL 4x4_acc: got %h want %h", out_acc, e.acc); end
    vectors++; if (out_beats !== e.beats) begin miscompares++; $display("FAIL 4x4_beats: got %0d want %0d", out_beats, e.beats); end
    vectors++; if (out_ovf !== e.ovf || out_err !== e.err) begin miscompares++; $display("FAIL 4x4_flags: got ovf=%b err=%b want ovf=%b err=%b", out_ovf, out_err, e.ovf, e.err); end
    $display("4x4: acc=%h beats=%0d", out_acc, out_beats);
    take_result();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL 4x4_release: got %b want 0", out_valid); end
  endtask

  task automatic test_2x6();
    exp_t e;
    mode = 2'b01;
    send_beat(1'b0, 16'h3F01, 1'b0);
    send_beat(1'b0, 16'h0203, 1'b1);
    sb.push_back(mk_exp(pack4(4, 1, 0, 0), 2, 4'b0000, 1'b0));
    e = sb.pop_front();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL 2x6_valid: got %b want 1", out_valid); end
    vectors++; if (out_acc !== e.acc) begin miscompares++; $display("FAIL 2x6_acc: got %h want %h", out_acc, e.acc); end
    vectors++; if (out_beats !== e.beats || out_ovf !== e.ovf || out_err !== e.err) begin miscompares++; $display("FAIL 2x6_status: got beats=%0d ovf=%b err=%b want %0d %b %b", out_beats, out_ovf, out_err, e.beats, e.ovf, e.err); end
    $display("2x6: acc=%h beats=%0d", out_acc, out_beats);
    take_result();
  endtask

  task automatic test_1x8_overflow();
    exp_t e;
    mode = 2'b10;
    for (int b = 0; b < 4; b++) send_beat(1'b0, 16'h0080, 1'b0);
    send_beat(1'b0, 16'h0080, 1'b1);
`ifdef FUSION_ACC_SAT_EN
    sb.push_back(mk_exp(pack4(-512, 0, 0, 0), 5, 4'b0001, 1'b0));
`else
    sb.push_back(mk_exp(pack4(384, 0, 0, 0), 5, 4'b0001, 1'b0));
`endif
    e = sb.pop_front();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL 1x8_valid: got %b want 1", out_valid); end
    vectors++; if (out_acc !== e.acc) begin miscompares++; $display("FAIL 1x8_acc: got %h want %h", out_acc, e.acc); end
    vectors++; if (out_ovf !== e.ovf) begin miscompares++; $display("FAIL 1x8_ovf: got %b want %b", out_ovf, e.ovf); end
    vectors++; if (out_beats !== e.beats || out_err !== e.err) begin miscompares++; $display("FAIL 1x8_status: got beats=%0d err=%b want %0d %b", out_beats, out_err, e.beats, e.err); end
    $display("1x8: acc=%h ovf=%b beats=%0d", out_acc, out_ovf, out_beats);
    take_result();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mode = 2'b00;
    send_beat(1'b0, 16'h4321, 1'b0);
    send_beat(1'b0, 16'h1111, 1'b1);
    sb.push_back(mk_exp(pack4(2, 3, 4, 5), 2, 4'b0000, 1'b0));
    e = sb.pop_front();
    in_valid = 1'b1; in_data = 16'h0002; in_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready cycle %0d: got %b want 0", c, in_ready); end
      vectors++; if (out_acc !== e.acc) begin miscompares++; $display("FAIL bp_acc cycle %0d: got %h want %h", c, out_acc, e.acc); end
      @(posedge clk); #1;
    end
    vectors++; if (out_valid !== 1'b1 || out_beats !== e.beats) begin miscompares++; $display("FAIL bp_hold: got valid=%b beats=%0d want 1 %0d", out_valid, out_beats, e.beats); end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_comb: got %b want 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid: got %b want 0", out_valid); end
    vectors++; if (out_beats !== 9'd1) begin miscompares++; $display("FAIL b2b_beats: got %0d want 1", out_beats); end
    vectors++; if (out_acc !== pack4(2, 0, 0, 0)) begin miscompares++; $display("FAIL b2b_load: got %h want %h", out_acc, pack4(2, 0, 0, 0)); end
    send_beat(1'b0, 16'h0001, 1'b1);
    sb.push_back(mk_exp(pack4(3, 0, 0, 0), 2, 4'b0000, 1'b0));
    e = sb.pop_front();
    vectors++; if (out_valid !== 1'b1 || out_acc !== e.acc || out_beats !== e.beats) begin miscompares++; $display("FAIL b2b_result: got valid=%b acc=%h beats=%0d want 1 %h %0d", out_valid, out_acc, out_beats, e.acc, e.beats); end
    $display("back_to_back: second burst acc=%h beats=%0d", out_acc, out_beats);
    take_result();
  endtask

  task automatic test_max_beats();
    exp_t e;
    m_mode = 2'b00;
    for (int b = 0; b < 3; b++) send_beat(1'b1, 16'h0001, 1'b0);
    vectors++; if (m_out_valid !== 1'b0) begin miscompares++; $display("FAIL max_early_valid: got %b want 0", m_out_valid); end
    send_beat(1'b1, 16'h0001, 1'b0);
    sb.push_back(mk_exp(pack4(4, 0, 0, 0), 4, 4'b0000, 1'b1));
    e = sb.pop_front();
    vectors++; if (m_out_valid !== 1'b1) begin miscompares++; $display("FAIL max_forced_valid: got %b want 1", m_out_valid); end
    vectors++; if (m_out_err !== e.err) begin miscompares++; $display("FAIL max_err: got %b want %b", m_out_err, e.err); end
    vectors++; if (m_out_beats !== e.beats[M_CNT_W-1:0] || m_out_acc !== e.acc) begin miscompares++; $display("FAIL max_result: got beats=%0d acc=%h want %0d %h", m_out_beats, m_out_acc, e.beats, e.acc); end
    vectors++; if (m_in_ready !== 1'b0) begin miscompares++; $display("FAIL max_hold_ready: got %b want 0", m_in_ready); end
    m_out_ready = 1'b1;
    send_beat(1'b1, 16'h0001, 1'b0);
    m_out_ready = 1'b0;
    vectors++; if (m_out_valid !== 1'b0 || m_out_beats !== 3'd1 || m_out_err !== 1'b0) begin miscompares++; $display("FAIL max_restart: got valid=%b beats=%0d err=%b want 0 1 0", m_out_valid, m_out_beats, m_out_err); end
    send_beat(1'b1, 16'h0001, 1'b0);
    vectors++; if (m_out_beats !== 3'd2 || m_out_valid !== 1'b0) begin miscompares++; $display("FAIL max_sixth: got beats=%0d valid=%b want 2 0", m_out_beats, m_out_valid); end
    $display("max_beats: forced HOLD at 4, new burst beats=%0d", m_out_beats);
  endtask

  task automatic test_reset_mid_illegal();
    exp_t e;
    mode = 2'b00;
    send_beat(1'b0, 16'h1111, 1'b0);
    send_beat(1'b0, 16'h1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_acc !== '0 || out_beats !== '0) begin miscompares++; $display("FAIL midrst_clear: got acc=%h beats=%0d want 0 0", out_acc, out_beats); end
    vectors++; if (out_valid !== 1'b0 || out_err !== 1'b0 || out_ovf !== 4'b0) begin miscompares++; $display("FAIL midrst_flags: got valid=%b err=%b ovf=%b want 0", out_valid, out_err, out_ovf); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mode = 2'b11;
    send_beat(1'b0, 16'h1234, 1'b0);
    send_beat(1'b0, 16'h5678, 1'b1);
    sb.push_back(mk_exp(pack4(0, 0, 0, 0), 2, 4'b0000, 1'b1));
    e = sb.pop_front();
    vectors++; if (out_valid !== 1'b1 || out_beats !== e.beats) begin miscompares++; $display("FAIL ill_beats: got valid=%b beats=%0d want 1 %0d", out_valid, out_beats, e.beats); end
    vectors++; if (out_acc !== e.acc) begin miscompares++; $display("FAIL ill_acc: got %h want %h", out_acc, e.acc); end
    vectors++; if (out_err !== e.err || out_ovf !== e.ovf) begin miscompares++; $display("FAIL ill_err: got err=%b ovf=%b want %b %b", out_err, out_ovf, e.err, e.ovf); end
    $display("reset_mid/illegal: acc=%h beats=%0d err=%b", out_acc, out_beats, out_err);
    take_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_4x4();
    test_2x6();
    test_1x8_overflow();
    test_back_to_back();
    test_max_beats();
    test_reset_mid_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
